// File: rtl/calc_pkg.sv
// Shared key codes, state and operator encodings for the calculator entry block.
package calc_pkg;

  // Key codes delivered by the keypad cursor
  localparam logic [4:0] K_DIG_MAX = 5'h0F;
  localparam logic [4:0] K_ADD     = 5'h10;
  localparam logic [4:0] K_MUL     = 5'h11;
  localparam logic [4:0] K_AND     = 5'h12;
  localparam logic [4:0] K_EXE     = 5'h13;
  localparam logic [4:0] K_SUB     = 5'h14;
  localparam logic [4:0] K_OR      = 5'h15;
  localparam logic [4:0] K_CE      = 5'h16;
  localparam logic [4:0] K_CLR     = 5'h17;

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'd0,
    ST_ENTER_B = 2'd1,
    ST_RESULT  = 2'd2
  } state_t;

  // Operator encoding is the low three bits of the operator key code
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_MUL = 3'd1,
    OP_AND = 3'd2,
    OP_SUB = 3'd4,
    OP_OR  = 3'd5
  } op_t;

  // True for the five keys that select an arithmetic/logic operation
  function automatic logic is_operator(input logic [4:0] k);
    return (k == K_ADD) || (k == K_MUL) || (k == K_AND) ||
           (k == K_SUB) || (k == K_OR);
  endfunction

endpackage

// File: rtl/calc_entry_if.sv
// Key input and display/status output bundle between the cursor/display side
// (master) and the calculator entry block (slave).
interface calc_entry_if #(
  parameter int W = 16
);
  logic         key_valid;
  logic [4:0]   key_val;
  logic         hex_mode;
  logic         restriction;
  logic [W-1:0] display_val;
  logic [1:0]   state;
  logic [2:0]   op;
  logic         overflow;
  logic         negative;

  modport master (
    output key_valid, key_val, hex_mode,
    input  restriction, display_val, state, op, overflow, negative
  );

  modport slave (
    input  key_valid, key_val, hex_mode,
    output restriction, display_val, state, op, overflow, negative
  );
endinterface

// File: rtl/calc_alu.sv
// Combinational ALU: W-bit results with carry/high-half overflow and borrow flag.
module calc_alu
  import calc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_t          op,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         negative
);

  logic [W:0]     sum;
  logic [2*W-1:0] prod;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  // Select the operation; flags that do not apply to an op read as zero
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    negative = 1'b0;
    case (op)
      OP_ADD: begin
        result   = sum[W-1:0];
        overflow = sum[W];
      end
      OP_SUB: begin
        result   = a - b;
        negative = (a < b);
      end
      OP_MUL: begin
        result   = prod[W-1:0];
        overflow = |prod[2*W-1:W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/calc_entry.sv
// Calculator entry: turns qualified key codes into two operands, an operator
// and a computed result, and drives the cursor's A-F lockout.
module calc_entry
  import calc_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int W      = 16
) (
  input  logic         clk,
  input  logic         rst,
  calc_entry_if.slave  bus
);

  localparam int CW = $clog2(DIGITS + 1);

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  op_t           op_q, op_d;
  state_t        state_q, state_d;
  logic          ovf_q, ovf_d;
  logic          neg_q, neg_d;
  logic          mode_q, mode_d;
  logic          restr_q, restr_d;

  logic [W-1:0]  alu_res;
  logic          alu_ovf;
  logic          alu_neg;
  logic          is_digit;
  logic [3:0]    dig;
  logic          digit_ok;
  logic          cnt_full;
  logic          clear;

  calc_alu #(.W(W)) u_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result   (alu_res),
    .overflow (alu_ovf),
    .negative (alu_neg)
  );

  // Shift a new digit into an operand; decimal entry never exceeds 9999 so
  // the multiply-add cannot wrap at the 16-bit width
  function automatic logic [W-1:0] append(input logic [W-1:0] v,
                                          input logic [3:0]   d,
                                          input logic         hex);
    if (hex) return {v[W-5:0], d};
    return (v * W'(10)) + {{(W-4){1'b0}}, d};
  endfunction

  assign is_digit = (bus.key_val <= K_DIG_MAX);
  assign dig      = bus.key_val[3:0];
  // A-F is refused in decimal mode even though the cursor already blocks it
  assign digit_ok = is_digit && (mode_q || (dig <= 4'd9));
  assign cnt_full = (cnt_q == CW'(DIGITS));

  // Next-state decode for the entry FSM, operands and flags
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    state_d = state_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    mode_d  = mode_q;
    clear   = 1'b0;

    if (bus.hex_mode != mode_q) begin
      // A mode switch wipes everything and swallows any same-cycle key
      mode_d = bus.hex_mode;
      clear  = 1'b1;
    end else if (bus.key_valid) begin
      if (is_operator(bus.key_val)) begin
        case (state_q)
          ST_ENTER_A: begin
            op_d    = op_t'(bus.key_val[2:0]);
            b_d     = '0;
            cnt_d   = '0;
            state_d = ST_ENTER_B;
          end
          ST_ENTER_B: begin
            // Operator may be changed only before any B digit is typed
            if (cnt_q == '0) op_d = op_t'(bus.key_val[2:0]);
          end
          ST_RESULT: begin
            // Chain: previous result becomes the new left operand
            a_d     = res_q;
            op_d    = op_t'(bus.key_val[2:0]);
            b_d     = '0;
            cnt_d   = '0;
            state_d = ST_ENTER_B;
          end
          default: ;
        endcase
      end else if (bus.key_val == K_EXE) begin
        if (state_q == ST_ENTER_B) begin
          res_d   = alu_res;
          ovf_d   = alu_ovf;
          neg_d   = alu_neg;
          state_d = ST_RESULT;
        end
      end else if (bus.key_val == K_CE) begin
        case (state_q)
          ST_ENTER_A: begin
            a_d   = '0;
            cnt_d = '0;
          end
          ST_ENTER_B: begin
            b_d   = '0;
            cnt_d = '0;
          end
          default: clear = 1'b1;
        endcase
      end else if (bus.key_val == K_CLR) begin
        clear = 1'b1;
      end else if (digit_ok) begin
        case (state_q)
          ST_ENTER_A: begin
            if (!cnt_full) begin
              a_d   = append(a_q, dig, mode_q);
              cnt_d = cnt_q + CW'(1);
            end
          end
          ST_ENTER_B: begin
            if (!cnt_full) begin
              b_d   = append(b_q, dig, mode_q);
              cnt_d = cnt_q + CW'(1);
            end
          end
          ST_RESULT: begin
            // Typing a digit after a result starts a fresh calculation
            a_d     = {{(W-4){1'b0}}, dig};
            cnt_d   = CW'(1);
            state_d = ST_ENTER_A;
          end
          default: ;
        endcase
      end
    end

    if (clear) begin
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      cnt_d   = '0;
      op_d    = OP_ADD;
      state_d = ST_ENTER_A;
      ovf_d   = 1'b0;
      neg_d   = 1'b0;
    end

    restr_d = ~mode_d;
  end

  // State registers; reset captures the current mode and holds the lockout high
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      state_q <= ST_ENTER_A;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      mode_q  <= bus.hex_mode;
      restr_q <= 1'b1;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
      mode_q  <= mode_d;
      restr_q <= restr_d;
    end
  end

  // Display follows the operand or result belonging to the current state
  always_comb begin
    case (state_q)
      ST_ENTER_B: bus.display_val = b_q;
      ST_RESULT:  bus.display_val = res_q;
      default:    bus.display_val = a_q;
    endcase
  end

  assign bus.restriction = restr_q;
  assign bus.state       = state_q;
  assign bus.op          = op_q;
  assign bus.overflow    = ovf_q;
  assign bus.negative    = neg_q;

endmodule

// File: tb/tb_calc_entry.sv
// Directed bench for calc_entry: each checked step pushes its expected outputs
// to a scoreboard, which is popped and compared one cycle later.
module tb_calc_entry;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_entry_if #(.W(16)) bus ();

  calc_entry #(.DIGITS(4), .W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic [15:0] disp;
    logic [1:0]  st;
    logic [2:0]  op;
    logic        ovf;
    logic        neg;
    logic        restr;
  } exp_t;

  exp_t sb[$];
  exp_t none;
  int   checks = 0;
  int   fails  = 0;
  logic hm     = 1'b1;

  function automatic exp_t mk(string t, logic [15:0] d, logic [1:0] s,
                              logic [2:0] o, logic ov, logic ng, logic rs);
    exp_t e;
    e.tag = t; e.disp = d; e.st = s; e.op = o;
    e.ovf = ov; e.neg = ng; e.restr = rs;
    return e;
  endfunction

  task automatic cmp(string tag, string fld, logic [15:0] obs, logic [15:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    e = sb.pop_front();
    cmp(e.tag, "display", bus.display_val, e.disp);
    cmp(e.tag, "state",   {14'd0, bus.state}, {14'd0, e.st});
    cmp(e.tag, "op",      {13'd0, bus.op}, {13'd0, e.op});
    cmp(e.tag, "ovf",     {15'd0, bus.overflow}, {15'd0, e.ovf});
    cmp(e.tag, "neg",     {15'd0, bus.negative}, {15'd0, e.neg});
    cmp(e.tag, "restr",   {15'd0, bus.restriction}, {15'd0, e.restr});
    $display("step %-12s disp=%h state=%0d op=%0d ovf=%0b neg=%0b restr=%0b",
             e.tag, bus.display_val, bus.state, bus.op, bus.overflow,
             bus.negative, bus.restriction);
  endtask

  // One clock of stimulus; the previous step's expectation is checked first
  task automatic step(input logic r, input logic v, input logic [4:0] k,
                      input bit chk, input exp_t e);
    @(negedge clk);
    if (sb.size() > 0) check_pop();
    rst           = r;
    bus.hex_mode  = hm;
    bus.key_valid = v;
    bus.key_val   = k;
    if (chk) sb.push_back(e);
  endtask

  task automatic press(input logic [4:0] k);
    step(1'b0, 1'b1, k, 1'b0, none);
  endtask

  task automatic press_chk(input logic [4:0] k, input exp_t e);
    step(1'b0, 1'b1, k, 1'b1, e);
  endtask

  task automatic idle_chk(input exp_t e);
    step(1'b0, 1'b0, 5'h00, 1'b1, e);
  endtask

  logic [31:0] prod;

  initial begin
    bus.key_valid = 1'b0;
    bus.key_val   = 5'h00;
    bus.hex_mode  = 1'b1;
    prod = 32'd9999 * 32'd9999;

    // Reset: lockout high during reset, cleared one cycle after release in hex
    step(1'b1, 1'b0, 5'h00, 1'b1, mk("reset", 16'h0, 2'd0, 3'd0, 0, 0, 1));
    idle_chk(mk("post_rst", 16'h0, 2'd0, 3'd0, 0, 0, 0));

    // Hex: 1 A ADD 0 6 EXE -> 0x20
    press(5'h01);
    press_chk(5'h0A, mk("hex_A", 16'h001A, 2'd0, 3'd0, 0, 0, 0));
    press_chk(K_ADD, mk("hex_add", 16'h0000, 2'd1, 3'd0, 0, 0, 0));
    press(5'h00);
    press_chk(5'h06, mk("hex_B", 16'h0006, 2'd1, 3'd0, 0, 0, 0));
    press_chk(K_EXE, mk("hex_exe", 16'h0020, 2'd2, 3'd0, 0, 0, 0));
    press_chk(K_EXE, mk("res_exe", 16'h0020, 2'd2, 3'd0, 0, 0, 0));
    press_chk(K_CLR, mk("clr", 16'h0000, 2'd0, 3'd0, 0, 0, 0));

    // EXE and 0x1F ignored in ENTER_A; operator replaced while B empty
    press(5'h05);
    press_chk(K_EXE, mk("exe_in_A", 16'h0005, 2'd0, 3'd0, 0, 0, 0));
    press_chk(5'h1F, mk("key_1F", 16'h0005, 2'd0, 3'd0, 0, 0, 0));
    press(K_ADD);
    press_chk(K_OR, mk("op_repl", 16'h0000, 2'd1, 3'd5, 0, 0, 0));
    press(5'h03);
    press_chk(K_EXE, mk("or_exe", 16'h0007, 2'd2, 3'd5, 0, 0, 0));

    // CE in ENTER_A, ENTER_B and RESULT
    press(K_CLR);
    press(5'h08);
    press_chk(K_CE, mk("ce_A", 16'h0000, 2'd0, 3'd0, 0, 0, 0));
    press(5'h07);
    press(K_ADD);
    press(5'h04);
    press_chk(K_CE, mk("ce_B", 16'h0000, 2'd1, 3'd0, 0, 0, 0));
    press_chk(K_EXE, mk("ce_B_exe", 16'h0007, 2'd2, 3'd0, 0, 0, 0));
    press_chk(K_CE, mk("ce_res", 16'h0000, 2'd0, 3'd0, 0, 0, 0));

    // Switch to decimal: full clear, lockout raised
    hm = 1'b0;
    idle_chk(mk("dec_mode", 16'h0000, 2'd0, 3'd0, 0, 0, 1));
    press(5'h09);
    press_chk(5'h0A, mk("dec_hexdig", 16'd9, 2'd0, 3'd0, 0, 0, 1));
    press(5'h09);
    press(5'h09);
    press(5'h09);
    press_chk(5'h09, mk("dec_5th", 16'd9999, 2'd0, 3'd0, 0, 0, 1));
    press(K_MUL);
    press(5'h09);
    press(5'h09);
    press(5'h09);
    press_chk(5'h09, mk("dec_B", 16'd9999, 2'd1, 3'd1, 0, 0, 1));
    press_chk(K_EXE, mk("mul", prod[15:0], 2'd2, 3'd1, |prod[31:16], 0, 1));

    // SUB borrow, then chained ADD wrapping to zero
    press(K_CLR);
    press(5'h03);
    press(K_SUB);
    press(5'h05);
    press_chk(K_EXE, mk("sub", 16'hFFFE, 2'd2, 3'd4, 0, 1, 1));
    press_chk(K_ADD, mk("chain_op", 16'h0000, 2'd1, 3'd0, 0, 1, 1));
    press(5'h02);
    press_chk(K_EXE, mk("chain", 16'h0000, 2'd2, 3'd0, 1, 0, 1));
    press_chk(5'h04, mk("res_digit", 16'h0004, 2'd0, 3'd0, 1, 0, 1));

    // Mode change coincident with key 3: cleared, key dropped
    press(K_CLR);
    press(5'h01);
    press_chk(5'h02, mk("dec_12", 16'd12, 2'd0, 3'd0, 0, 0, 1));
    hm = 1'b1;
    press_chk(5'h03, mk("mode_chg", 16'h0000, 2'd0, 3'd0, 0, 0, 0));
    idle_chk(mk("mode_chg2", 16'h0000, 2'd0, 3'd0, 0, 0, 0));

    // Reset mid-entry in ENTER_B with B = 0x12
    press(5'h01);
    press(K_ADD);
    press(5'h01);
    press_chk(5'h02, mk("B_12", 16'h0012, 2'd1, 3'd0, 0, 0, 0));
    step(1'b1, 1'b0, 5'h00, 1'b1, mk("mid_rst", 16'h0000, 2'd0, 3'd0, 0, 0, 1));
    idle_chk(mk("rst_rel", 16'h0000, 2'd0, 3'd0, 0, 0, 0));
    step(1'b0, 1'b0, 5'h00, 1'b0, none);

    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL scoreboard leftover=%0d required=0", sb.size());
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
